// File: rtl/rot_pkg.sv
// rot_pkg: shared definitions for the front-panel rotary register selector.
// Provides the position encoding seen by the rotary decoder plus the
// wrap/saturate helpers used by the position keeper.
package rot_pkg;

   typedef logic [3:0] rot_pos_t;

   localparam rot_pos_t ROT_POS_R0 = 4'd0;
   localparam rot_pos_t ROT_POS_R1 = 4'd1;
   localparam rot_pos_t ROT_POS_R2 = 4'd2;
   localparam rot_pos_t ROT_POS_R3 = 4'd3;
   localparam rot_pos_t ROT_POS_R4 = 4'd4;
   localparam rot_pos_t ROT_POS_R5 = 4'd5;
   localparam rot_pos_t ROT_POS_R6 = 4'd6;
   localparam rot_pos_t ROT_POS_R7 = 4'd7;
   localparam rot_pos_t ROT_POS_IC = 4'd8;
   localparam rot_pos_t ROT_POS_AC = 4'd9;
   localparam rot_pos_t ROT_POS_AR = 4'd10;
   localparam rot_pos_t ROT_POS_IR = 4'd11;
   localparam rot_pos_t ROT_POS_SR = 4'd12;
   localparam rot_pos_t ROT_POS_RZ = 4'd13;
   localparam rot_pos_t ROT_POS_KB = 4'd14;

   localparam rot_pos_t ROT_POS_MAX = ROT_POS_KB;

   // Next position going "up": KB wraps back to R0. Anything out of range
   // is treated as the top so the counter can never settle on 15.
   function automatic rot_pos_t rot_step_up(input rot_pos_t p);
      rot_pos_t r;
      if (p >= ROT_POS_MAX) r = ROT_POS_R0;
      else                  r = p + 4'd1;
      return r;
   endfunction

   // Next position going "down": R0 wraps to KB.
   function automatic rot_pos_t rot_step_down(input rot_pos_t p);
      rot_pos_t r;
      if (p == ROT_POS_R0 || p > ROT_POS_MAX) r = ROT_POS_MAX;
      else                                    r = p - 4'd1;
      return r;
   endfunction

   // Direct-load value: 15 has no register behind it, clamp to KB.
   function automatic rot_pos_t rot_load_sat(input rot_pos_t v);
      rot_pos_t r;
      if (v > ROT_POS_MAX) r = ROT_POS_MAX;
      else                 r = v;
      return r;
   endfunction

endpackage

// File: rtl/rot_debounce.sv
// rot_debounce: two-flop synchroniser plus consecutive-sample debouncer for
// one raw panel button. 'level' is the accepted button state, 'rise' is a
// one-cycle pulse registered together with the rising flip of 'level'.
module rot_debounce #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic rise
);

   logic        sync1_reg;
   logic        sync2_reg;
   logic        level_reg;
   logic        rise_reg;
   logic [15:0] cnt_reg;

   // Synchronise, then count consecutive disagreeing samples; any agreeing
   // sample restarts the count so short glitches never reach 'level'.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
         cnt_reg   <= 16'd0;
      end else begin
         sync1_reg <= btn;
         sync2_reg <= sync1_reg;
         rise_reg  <= 1'b0;
         if (sync2_reg == level_reg) begin
            cnt_reg <= 16'd0;
         end else if (cnt_reg == DEBOUNCE_CYCLES - 16'd1) begin
            level_reg <= sync2_reg;
            rise_reg  <= sync2_reg;
            cnt_reg   <= 16'd0;
         end else begin
            cnt_reg <= cnt_reg + 16'd1;
         end
      end
   end

   assign level = level_reg;
   assign rise  = rise_reg;

endmodule

// File: rtl/rot_pos.sv
// rot_pos: MERA-400 front-panel rotary register-selector position keeper.
// Debounced up/down buttons step the position through R0..R7, IC, AC, AR,
// IR, SR, RZ, KB (0..14, wrapping); set_valid loads a position directly and
// takes priority over any button step.
// Build option: define ROT_POS_AUTOREPEAT_EN to add hold-to-repeat stepping
// (REPEAT_DELAY before the first repeat, REPEAT_PERIOD between repeats).
module rot_pos
   import rot_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
   parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       set_valid,
   input  logic [3:0] set_pos,
   output logic [3:0] pos,
   output logic       changed
);

   // Index 0 is the "up" button, index 1 the "down" button.
   logic [1:0] btn_vec;
   logic [1:0] level;
   logic [1:0] rise;
   logic [1:0] rep;
   logic [1:0] step_req;

   rot_pos_t   pos_reg;
   rot_pos_t   pos_next;
   logic       changed_reg;
   logic       changed_next;

   assign btn_vec = {btn_down, btn_up};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi = gi + 1) begin : g_btn
         rot_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk_sys (clk_sys),
            .rst_n   (rst_n),
            .btn     (btn_vec[gi]),
            .level   (level[gi]),
            .rise    (rise[gi])
         );
      end
   endgenerate

`ifdef ROT_POS_AUTOREPEAT_EN
   generate
      for (gi = 0; gi < 2; gi = gi + 1) begin : g_rep
         logic [23:0] rep_cnt_reg;
         logic        rep_period_reg;
         logic        held;
         logic [23:0] rep_limit;

         // Only a lone held button repeats; the opposite button blocks it.
         assign held      = level[gi] & ~level[1 - gi];
         assign rep_limit = rep_period_reg ? REPEAT_PERIOD : REPEAT_DELAY;
         assign rep[gi]   = held & ~rise[gi] & ~set_valid &
                            (rep_cnt_reg == rep_limit - 24'd1);

         // Hold timer: restarts on the press step, release, the other
         // button or a direct load; switches to the period after a repeat.
         always_ff @(posedge clk_sys) begin
            if (!rst_n) begin
               rep_cnt_reg    <= 24'd0;
               rep_period_reg <= 1'b0;
            end else if (!held || set_valid || rise[gi]) begin
               rep_cnt_reg    <= 24'd0;
               rep_period_reg <= 1'b0;
            end else if (rep[gi]) begin
               rep_cnt_reg    <= 24'd0;
               rep_period_reg <= 1'b1;
            end else begin
               rep_cnt_reg    <= rep_cnt_reg + 24'd1;
            end
         end
      end
   endgenerate
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
   assign rep = 2'b00;
`endif

   assign step_req = rise | rep;

   // Next position: load beats steps, and opposing steps cancel out.
   always_comb begin
      pos_next     = pos_reg;
      changed_next = 1'b0;
      if (set_valid) begin
         pos_next     = rot_load_sat(set_pos);
         changed_next = 1'b1;
      end else if (step_req == 2'b01) begin
         pos_next     = rot_step_up(pos_reg);
         changed_next = 1'b1;
      end else if (step_req == 2'b10) begin
         pos_next     = rot_step_down(pos_reg);
         changed_next = 1'b1;
      end
   end

   // Position and change-pulse registers.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         pos_reg     <= ROT_POS_R0;
         changed_reg <= 1'b0;
      end else begin
         pos_reg     <= pos_next;
         changed_reg <= changed_next;
      end
   end

   assign pos     = pos_reg;
   assign changed = changed_reg;

endmodule
